spi_master: RTL and testbench

Register-bus SPI master that issues the team's 40-bit register frame (1 read/write_n bit, ASZ address bits, DSZ data bits, MSB first) to the on-FPGA `spi_slave` or any compatible register slave. Mode 0 (CPOL=0, CPHA=0), single system clock, clock-divided SCK. It is used by local sequencers and by the test harness to drive a slave register file. A start/ready handshake launches each frame, and a one-cycle `done` pulse reports completion with captured read data.

---
 rtl/spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_spi_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master: sends one {rw, addr, wdat} register frame MSB first and captures read data.
// Optional macro SPIM_CSGAP_EN adds a GAP state that holds chip select high for CSGAP cycles.
module spi_master #(
   parameter int ASZ   = 7,
   parameter int DSZ   = 32,
   parameter int DIV   = 4,
   parameter int CSGAP = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           rw,
   input  logic [ASZ-1:0] addr,
   input  logic [DSZ-1:0] wdat,
   output logic           ready,
   output logic           done,
   output logic [DSZ-1:0] rdat,
   output logic           spiclk,
   output logic           spimosi,
   input  logic           spimiso,
   output logic           spicsl
);

   localparam int FL = 1 + ASZ + DSZ;
   localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(FL);
   localparam logic [HW-1:0] HALF_LAST = HW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(FL - 1);

`ifdef SPIM_CSGAP_EN
   localparam int GW = (CSGAP > 1) ? $clog2(CSGAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(CSGAP - 1);
   typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD} state_t;
`endif

   state_t          r_state, w_state;
   logic [HW-1:0]   r_half,  w_half;
   logic [BW-1:0]   r_bit,   w_bit;
   // The frame MSB (rw) goes straight to MOSI on accept, so only the remaining bits are held.
   logic [FL-2:0]   r_tx,    w_tx;
   logic [DSZ-1:0]  r_rx,    w_rx;
   logic            r_rw,    w_rw;
   logic            r_ready, w_ready;
   logic            r_done,  w_done;
   logic [DSZ-1:0]  r_rdat,  w_rdat;
   logic            r_sck,   w_sck;
   logic            r_mosi,  w_mosi;
   logic            r_csl,   w_csl;
`ifdef SPIM_CSGAP_EN
   logic [GW-1:0]   r_gap,   w_gap;
`endif

   logic            w_half_end;

   assign w_half_end = (r_half == HALF_LAST);

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         r_state <= S_IDLE;
         r_half  <= '0;
         r_bit   <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_rw    <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_rdat  <= '0;
         r_sck   <= 1'b0;
         r_mosi  <= 1'b0;
         r_csl   <= 1'b1;
`ifdef SPIM_CSGAP_EN
         r_gap   <= '0;
`endif
      end else begin
         r_state <= w_state;
         r_half  <= w_half;
         r_bit   <= w_bit;
         r_tx    <= w_tx;
         r_rx    <= w_rx;
         r_rw    <= w_rw;
         r_ready <= w_ready;
         r_done  <= w_done;
         r_rdat  <= w_rdat;
         r_sck   <= w_sck;
         r_mosi  <= w_mosi;
         r_csl   <= w_csl;
`ifdef SPIM_CSGAP_EN
         r_gap   <= w_gap;
`endif
      end
   end

   always_comb begin
      // NOTE: every target gets a default first, so no path through the case can infer a latch.
      w_state = r_state;
      w_half  = r_half;
      w_bit   = r_bit;
      w_tx    = r_tx;
      w_rx    = r_rx;
      w_rw    = r_rw;
      w_ready = r_ready;
      w_done  = 1'b0;
      w_rdat  = r_rdat;
      w_sck   = r_sck;
      w_mosi  = r_mosi;
      w_csl   = r_csl;
`ifdef SPIM_CSGAP_EN
      w_gap   = r_gap;
`endif

      case (r_state)
         S_IDLE: begin
            w_half = '0;
            if (r_ready && start) begin
               w_tx    = {addr, wdat};
               w_rw    = rw;
               w_mosi  = rw;
               w_ready = 1'b0;
               w_csl   = 1'b0;
               w_bit   = '0;
               w_state = S_LOW;
            end else begin
               w_ready = 1'b1;
            end
         end

         S_LOW: begin
            if (w_half_end) begin
               w_half  = '0;
               w_sck   = 1'b1;
               w_rx    = {r_rx[DSZ-2:0], spimiso};
               w_state = S_HIGH;
            end else begin
               w_half = r_half + HW'(1);
            end
         end

         S_HIGH: begin
            if (w_half_end) begin
               w_half = '0;
               w_sck  = 1'b0;
               if (r_bit == BIT_LAST) begin
                  w_state = S_HOLD;
               end else begin
                  w_mosi  = r_tx[FL-2];
                  w_tx    = {r_tx[FL-3:0], 1'b0};
                  w_bit   = r_bit + BW'(1);
                  w_state = S_LOW;
               end
            end else begin
               w_half = r_half + HW'(1);
            end
         end

         S_HOLD: begin
            if (w_half_end) begin
               w_half = '0;
               w_csl  = 1'b1;
               w_mosi = 1'b0;
               w_done = 1'b1;
               // Only the last DSZ sampled bits survive in the rx shift: the data phase.
               if (r_rw) begin
                  w_rdat = r_rx;
               end
`ifdef SPIM_CSGAP_EN
               w_gap   = '0;
               w_state = S_GAP;
`else
               w_state = S_IDLE;
`endif
            end else begin
               w_half = r_half + HW'(1);
            end
         end

`ifdef SPIM_CSGAP_EN
         S_GAP: begin
            if (r_gap == GAP_LAST) begin
               w_ready = 1'b1;
               w_state = S_IDLE;
            end else begin
               w_gap = r_gap + GW'(1);
            end
         end
`endif

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign ready   = r_ready;
   assign done    = r_done;
   assign rdat    = r_rdat;
   assign spiclk  = r_sck;
   assign spimosi = r_mosi;
   assign spicsl  = r_csl;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (DIV = 1, 2, 255) checked against a frame-level model
// of MOSI content, CS width, SCK half-periods, done/rdat behaviour and reset abort.
module tb_spi_master;

   localparam int FL = 40;
`ifdef SPIM_CSGAP_EN
   localparam int READY_LAT = 8;
`else
   localparam int READY_LAT = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  reset_v, start_v, rw_v, miso_v;
   logic [6:0]  addr_v [3];
   logic [31:0] wdat_v [3];
   wire  [2:0]  ready_v, done_v, sck_v, mosi_v, csl_v;
   wire  [31:0] rdat_v [3];

   spi_master #(.ASZ(7), .DSZ(32), .DIV(1), .CSGAP(8)) u_dut_div1 (
      .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .rw(rw_v[0]), .addr(addr_v[0]),
      .wdat(wdat_v[0]), .ready(ready_v[0]), .done(done_v[0]), .rdat(rdat_v[0]),
      .spiclk(sck_v[0]), .spimosi(mosi_v[0]), .spimiso(miso_v[0]), .spicsl(csl_v[0]));

   spi_master #(.ASZ(7), .DSZ(32), .DIV(2), .CSGAP(8)) u_dut_div2 (
      .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .rw(rw_v[1]), .addr(addr_v[1]),
      .wdat(wdat_v[1]), .ready(ready_v[1]), .done(done_v[1]), .rdat(rdat_v[1]),
      .spiclk(sck_v[1]), .spimosi(mosi_v[1]), .spimiso(miso_v[1]), .spicsl(csl_v[1]));

   spi_master #(.ASZ(7), .DSZ(32), .DIV(255), .CSGAP(8)) u_dut_div255 (
      .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .rw(rw_v[2]), .addr(addr_v[2]),
      .wdat(wdat_v[2]), .ready(ready_v[2]), .done(done_v[2]), .rdat(rdat_v[2]),
      .spiclk(sck_v[2]), .spimosi(mosi_v[2]), .spimiso(miso_v[2]), .spicsl(csl_v[2]));

   function automatic int div_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 255;
   endfunction

   // Slave model: bit i of the 40-bit reply vector is presented before SCK rise i+1.
   logic [39:0] miso_vec [3];
   int          rise_idx [3] = '{0, 0, 0};

   always_comb begin
      miso_v = '0;
      for (int k = 0; k < 3; k++) begin
         if (rise_idx[k] < FL) miso_v[k] = miso_vec[k][FL-1-rise_idx[k]];
      end
   end

   // Bus monitor: rebuilds each frame from the pins, sampled on the falling clk edge.
   int          frames   [3] = '{0, 0, 0};
   int          dones    [3] = '{0, 0, 0};
   int          bad_half [3] = '{0, 0, 0};
   int          bad_mosi [3] = '{0, 0, 0};
   int          bad_done [3] = '{0, 0, 0};
   int          run      [3] = '{0, 0, 0};
   int          low_cnt  [3] = '{0, 0, 0};
   logic [39:0] cap      [3];
   logic [39:0] frame_log [3][8];
   int          low_log   [3][8];
   logic [31:0] done_rdat [3];
   logic        prev_c [3] = '{1'b1, 1'b1, 1'b1};
   logic        prev_s [3] = '{1'b0, 1'b0, 1'b0};
   logic        prev_m [3] = '{1'b0, 1'b0, 1'b0};

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (csl_v[k] === 1'b0 && prev_c[k] === 1'b1) begin
            rise_idx[k] = 0;
            cap[k]      = '0;
            low_cnt[k]  = 0;
         end
         if (csl_v[k] === 1'b0) low_cnt[k]++;
         if (sck_v[k] === 1'b1 && prev_s[k] === 1'b0) begin
            cap[k] = {cap[k][38:0], mosi_v[k]};
            rise_idx[k]++;
         end
         if (prev_c[k] === 1'b0) begin
            if (csl_v[k] === 1'b0 && sck_v[k] === prev_s[k]) run[k]++;
            else begin
               if (run[k] != div_of(k)) bad_half[k]++;
               run[k] = 1;
            end
         end else begin
            run[k] = 1;
         end
         if (mosi_v[k] !== prev_m[k] && !(prev_s[k] === 1'b1 && sck_v[k] === 1'b0) &&
             csl_v[k] === prev_c[k]) bad_mosi[k]++;
         if (csl_v[k] === 1'b1 && prev_c[k] === 1'b0) begin
            frame_log[k][frames[k] % 8] = cap[k];
            low_log[k][frames[k] % 8]   = low_cnt[k];
            frames[k]++;
         end
         if (done_v[k] === 1'b1) begin
            dones[k]++;
            done_rdat[k] = rdat_v[k];
            if (!(csl_v[k] === 1'b1 && prev_c[k] === 1'b0)) bad_done[k]++;
         end
         prev_c[k] = csl_v[k];
         prev_s[k] = sck_v[k];
         prev_m[k] = mosi_v[k];
      end
   end

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_rdat [3] = '{32'h0, 32'h0, 32'h0};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // One complete frame on instance k, with stray start pulses injected while busy.
   task automatic run_frame(input int k, input logic rw_i, input logic [6:0] a,
                            input logic [31:0] d, input logic [39:0] mv, input string tag);
      int          n, lat, f0, d0, bh0, bm0, bd0;
      logic [31:0] exp_rdat;
      miso_vec[k] = mv;
      n = 0;
      while (ready_v[k] !== 1'b1 && n < 1000) begin tick(); n++; end
      check({tag, "_ready_before"}, ready_v[k], 1'b1);
      f0 = frames[k]; d0 = dones[k]; bh0 = bad_half[k]; bm0 = bad_mosi[k]; bd0 = bad_done[k];
      rw_v[k] = rw_i; addr_v[k] = a; wdat_v[k] = d; start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
      n = 0;
      while (dones[k] == d0 && n < 30000) begin
         if (start_v[k] == 1'b0 && ready_v[k] === 1'b0 && csl_v[k] === 1'b0 && (n % 7) == 3) begin
            start_v[k] = 1'b1; rw_v[k] = ~rw_i; addr_v[k] = ~a; wdat_v[k] = ~d;
         end else begin
            start_v[k] = 1'b0;
         end
         tick();
         n++;
      end
      start_v[k] = 1'b0;
      check({tag, "_done_seen"}, dones[k] - d0, 1);
      check({tag, "_ready_in_done"}, ready_v[k], 1'b0);
      exp_rdat = rw_i ? mv[31:0] : model_rdat[k];
      model_rdat[k] = exp_rdat;
      check({tag, "_rdat_at_done"}, done_rdat[k], exp_rdat);
      lat = 0;
      while (ready_v[k] !== 1'b1 && lat < 100) begin tick(); lat++; end
      check({tag, "_ready_latency"}, lat, READY_LAT);
      check({tag, "_frames"}, frames[k] - f0, 1);
      check({tag, "_mosi_frame"}, frame_log[k][f0 % 8], {rw_i, a, d});
      check({tag, "_cs_low_cycles"}, low_log[k][f0 % 8], (2 * FL + 1) * div_of(k));
      check({tag, "_half_period_err"}, bad_half[k] - bh0, 0);
      check({tag, "_mosi_change_err"}, bad_mosi[k] - bm0, 0);
      check({tag, "_done_vs_cs_err"}, bad_done[k] - bd0, 0);
      check({tag, "_rdat_hold"}, rdat_v[k], exp_rdat);
   endtask

   initial begin
      int          n, f0, d0, bh0, bm0;
      logic [39:0] exp_fr [3];
      logic [39:0] mv;

      reset_v = '1; start_v = '0; rw_v = '0;
      for (int k = 0; k < 3; k++) begin
         addr_v[k] = '0; wdat_v[k] = '0; miso_vec[k] = '0;
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ready%0d", k), ready_v[k], 1'b1);
         check($sformatf("rst_done%0d",  k), done_v[k],  1'b0);
         check($sformatf("rst_rdat%0d",  k), rdat_v[k],  32'h0);
         check($sformatf("rst_sck%0d",   k), sck_v[k],   1'b0);
         check($sformatf("rst_mosi%0d",  k), mosi_v[k],  1'b0);
         check($sformatf("rst_csl%0d",   k), csl_v[k],   1'b1);
      end
      reset_v = '0;
      tick();

      run_frame(1, 1'b0, 7'h15, 32'hDEADBEEF, {$urandom, $urandom}, "wr_div2");
      run_frame(0, 1'b1, 7'h7F, 32'h0, {8'($urandom), 32'h12345678}, "rd_div1");
      run_frame(2, 1'b0, 7'h00, 32'hFFFFFFFF, {$urandom, $urandom}, "wr_div255");

      for (int i = 0; i < 8; i++) begin
         run_frame(i % 2, 1'($urandom), 7'($urandom), $urandom, {$urandom, $urandom},
                   $sformatf("rand%0d", i));
      end

      // Back-to-back: start held high across three frames on the DIV=2 instance.
      f0 = frames[1]; d0 = dones[1]; bh0 = bad_half[1]; bm0 = bad_mosi[1];
      miso_vec[1] = {$urandom, $urandom};
      rw_v[1] = 1'b0; addr_v[1] = 7'($urandom); wdat_v[1] = $urandom;
      start_v[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (ready_v[1] !== 1'b1 && n < 2000) begin tick(); n++; end
         check($sformatf("b2b_ready%0d", i), ready_v[1], 1'b1);
         exp_fr[i] = {rw_v[1], addr_v[1], wdat_v[1]};
         tick();
         if (i < 2) begin
            rw_v[1] = 1'($urandom); addr_v[1] = 7'($urandom); wdat_v[1] = $urandom;
         end else begin
            start_v[1] = 1'b0;
         end
      end
      n = 0;
      while (frames[1] - f0 < 3 && n < 2000) begin tick(); n++; end
      repeat (5) tick();
      check("b2b_frames", frames[1] - f0, 3);
      check("b2b_dones", dones[1] - d0, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_mosi%0d", i), frame_log[1][(f0 + i) % 8], exp_fr[i]);
         check($sformatf("b2b_cs_low%0d", i), low_log[1][(f0 + i) % 8], (2 * FL + 1) * 2);
      end
      check("b2b_half_period_err", bad_half[1] - bh0, 0);
      check("b2b_mosi_change_err", bad_mosi[1] - bm0, 0);

      // Reset abort on the DIV=1 instance after SCK rise 20 of a read.
      run_frame(0, 1'b1, 7'h2A, 32'h0, {8'h00, ($urandom | 32'h1)}, "rd_pre_abort");
      mv = {$urandom, $urandom};
      miso_vec[0] = mv;
      rw_v[0] = 1'b1; addr_v[0] = 7'h33; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      n = 0;
      while (rise_idx[0] < 20 && n < 500) begin tick(); n++; end
      check("abort_rise20_reached", rise_idx[0], 20);
      reset_v[0] = 1'b1;
      d0 = dones[0];
      tick();
      model_rdat[0] = 32'h0;
      check("abort_csl",   csl_v[0],   1'b1);
      check("abort_sck",   sck_v[0],   1'b0);
      check("abort_rdat",  rdat_v[0],  32'h0);
      check("abort_ready", ready_v[0], 1'b1);
      check("abort_done",  done_v[0],  1'b0);
      reset_v[0] = 1'b0;
      repeat (100) tick();
      check("abort_no_done", dones[0] - d0, 0);
      run_frame(0, 1'b1, 7'h01, 32'h0, {$urandom, $urandom}, "rd_post_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
